pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, next-generation inter-stage pipeline register for the 5-stage MIPS core. Usable as ID/EX, EX/MEM or MEM/WB.
- Carries NUM_DATA data lanes, NUM_RADDR register-address lanes and a packed control vector, plus a valid bit.
- Adds stall (hold), flush (bubble insertion) and upstream-bubble handling.
- Optional saturating performance counters for stall and bubble cycles.

Parameters:
- DATA_W, 32: width of each data lane (PC+4, ReadData1, ReadData2, sign-extended immediate).
- NUM_DATA, 4: number of data lanes.
- RADDR_W, 5: register-address width.
- NUM_RADDR, 2: number of register-address lanes (rt, rd).
- CTRL_W, 13: packed control width (RegWrite, MemtoReg, Branch, MemRead, MemWrite, RegDst, ALUOp[5:0], ALUSrc).
- CTRL_BUBBLE, 13'b0: control value loaded on reset, flush or upstream bubble; must encode no register write and no memory write.
- CNT_W, 16: performance counter width.

Ports:
- Clk_in, input, 1: clock; all state updates on its rising edge.
- Reset_n_in, input, 1: asynchronous, active-low reset.
- Stall_in, input, 1: hold all outputs this cycle.
- Flush_in, input, 1: replace stage contents with a bubble.
- Valid_in, input, 1: upstream stage holds a real instruction.
- Data_in, input, NUM_DATA*DATA_W: data lanes; lane k at [k*DATA_W +: DATA_W].
- Raddr_in, input, NUM_RADDR*RADDR_W: register-address lanes.
- Ctrl_in, input, CTRL_W: packed control.
- CntClr_in, input, 1: synchronous clear of the performance counters.
- Valid_out, output, 1: registered valid.
- Data_out, output, NUM_DATA*DATA_W: registered data lanes.
- Raddr_out, output, NUM_RADDR*RADDR_W: registered register addresses.
- Ctrl_out, output, CTRL_W: registered control.
- StallCnt_out, output, CNT_W: count of stall cycles.
- BubbleCnt_out, output, CNT_W: count of bubble cycles.

Behaviour:
- Reset (Reset_n_in=0, asynchronous, takes effect immediately):
  - Valid_out=0, Data_out=0, Raddr_out=0, Ctrl_out=CTRL_BUBBLE, both counters=0.
  - Reset asserted mid-stall or mid-flush overrides everything.
- Per-edge priority: Flush_in > Stall_in > load.
- Flush: Valid_out←0, Ctrl_out←CTRL_BUBBLE, Data_out←0, Raddr_out←0. Flush wins over a simultaneous stall.
- Stall (Flush_in=0): every output register holds its value; Valid_in, Data_in, Raddr_in and Ctrl_in are ignored.
- Load (Flush_in=0, Stall_in=0):
  - Valid_in=1: all fields are captured.
  - Valid_in=0: Valid_out←0 and Ctrl_out←CTRL_BUBBLE; data and address lanes are still captured (don't-care, kept for debug).
- Latency: exactly 1 cycle from input to output on load. Outputs are purely registered; there is no combinational input-to-output path.
- All assignments are non-blocking. Every lane is treated identically; no lane-specific logic.
- Leaving reset: the first edge after Reset_n_in rises performs a normal priority evaluation.
- Counters (with the optional feature only):
  - StallCnt increments on each edge with Stall_in=1 and Flush_in=0.
  - BubbleCnt increments on each edge where the newly written Valid_out is 0, whether from flush or an upstream bubble.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - CntClr_in=1 forces both to 0 on that edge; clear takes priority over an increment in the same cycle.
  - Counters are unaffected by stall hold; they count independently of the hold.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined: both counters are implemented as described in Behaviour.
- Undefined: StallCnt_out and BubbleCnt_out are tied to 0 and CntClr_in is ignored. No counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg holds:
  - control bit positions: CTRL_REGWRITE=0, CTRL_MEMTOREG=1, CTRL_BRANCH=2, CTRL_MEMREAD=3, CTRL_MEMWRITE=4, CTRL_REGDST=5, CTRL_ALUOP_LSB=6 (6 bits), CTRL_ALUSRC=12;
  - CTRL_W=13;
  - the default CTRL_BUBBLE;
  - lane index constants: LANE_PC=0, LANE_RD1=1, LANE_RD2=2, LANE_IMM=3.
- One sub-module, sat_counter: parametrised width, with inc, clr, async active-low reset. It is instantiated twice, inside the PIPE_STAGE_PERF_EN guard.

Test Plan:
- Reset: hold Reset_n_in=0 with random inputs and clock running → Valid_out=0, Data_out=0, Ctrl_out=13'h0000, counters=0. Assert Reset_n_in between clock edges → outputs clear without waiting for an edge.
- Load: Valid_in=1, lane0=32'h0000_0044, lane1=32'hDEAD_BEEF, Raddr_in={5'd9,5'd8}, Ctrl_in=13'h1A41 → exactly these values appear at the outputs one edge later.
- Stall: load value A, then Stall_in=1 for 3 cycles while presenting value B → outputs stay A; StallCnt=3. Release stall → B appears after one edge.
- Flush vs stall: Flush_in=1 and Stall_in=1 together → Valid_out=0, Ctrl_out=CTRL_BUBBLE, Data_out=0; BubbleCnt increments by 1 and StallCnt is unchanged.
- Upstream bubble: Valid_in=0 with Ctrl_in=13'h1FFF → Valid_out=0, Ctrl_out=0, and the lane data is captured.
- Saturation and build option: with CNT_W=4, 20 stall cycles → StallCnt=15; then CntClr_in=1 together with Stall_in=1 → StallCnt=0. Rebuild without PIPE_STAGE_PERF_EN → both counters read 0 throughout.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers: control-vector
// bit positions, the default bubble encoding and data-lane indices.
package pipe_pkg;

    localparam int unsigned CTRL_W = 13;

    localparam int unsigned CTRL_REGWRITE  = 0;
    localparam int unsigned CTRL_MEMTOREG  = 1;
    localparam int unsigned CTRL_BRANCH    = 2;
    localparam int unsigned CTRL_MEMREAD   = 3;
    localparam int unsigned CTRL_MEMWRITE  = 4;
    localparam int unsigned CTRL_REGDST    = 5;
    localparam int unsigned CTRL_ALUOP_LSB = 6;
    localparam int unsigned CTRL_ALUOP_W   = 6;
    localparam int unsigned CTRL_ALUSRC    = 12;

    // All-zero control: no register write, no memory access.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE_DFLT = '0;

    localparam int unsigned LANE_PC  = 0;
    localparam int unsigned LANE_RD1 = 1;
    localparam int unsigned LANE_RD2 = 2;
    localparam int unsigned LANE_IMM = 3;

    // True when a control word would change architectural state.
    function automatic logic ctrl_writes(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_REGWRITE] | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment) and
// asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register (ID/EX, EX/MEM, MEM/WB) with stall, flush and bubble handling.
// Stall/bubble performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_DATA  = 4,
    parameter int unsigned RADDR_W   = 5,
    parameter int unsigned NUM_RADDR = 2,
    parameter int unsigned CTRL_W    = pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(pipe_pkg::CTRL_BUBBLE_DFLT),
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          Clk_in,
    input  logic                          Reset_n_in,
    input  logic                          Stall_in,
    input  logic                          Flush_in,
    input  logic                          Valid_in,
    input  logic [NUM_DATA*DATA_W-1:0]    Data_in,
    input  logic [NUM_RADDR*RADDR_W-1:0]  Raddr_in,
    input  logic [CTRL_W-1:0]             Ctrl_in,
    input  logic                          CntClr_in,
    output logic                          Valid_out,
    output logic [NUM_DATA*DATA_W-1:0]    Data_out,
    output logic [NUM_RADDR*RADDR_W-1:0]  Raddr_out,
    output logic [CTRL_W-1:0]             Ctrl_out,
    output logic [CNT_W-1:0]              StallCnt_out,
    output logic [CNT_W-1:0]              BubbleCnt_out
);

    logic                         valid_q, valid_d;
    logic [NUM_DATA*DATA_W-1:0]   data_q, data_d;
    logic [NUM_RADDR*RADDR_W-1:0] raddr_q, raddr_d;
    logic [CTRL_W-1:0]            ctrl_q, ctrl_d;

    // Priority: flush > stall > load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        raddr_d = raddr_q;
        ctrl_d  = ctrl_q;
        if (Flush_in) begin
            valid_d = 1'b0;
            data_d  = '0;
            raddr_d = '0;
            ctrl_d  = CTRL_BUBBLE;
        end else if (!Stall_in) begin
            // Lanes are captured even for an upstream bubble to aid debug.
            valid_d = Valid_in;
            data_d  = Data_in;
            raddr_d = Raddr_in;
            ctrl_d  = Valid_in ? Ctrl_in : CTRL_BUBBLE;
        end
    end

    always_ff @(posedge Clk_in or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            raddr_q <= '0;
            ctrl_q  <= CTRL_BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            raddr_q <= raddr_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign Valid_out = valid_q;
    assign Data_out  = data_q;
    assign Raddr_out = raddr_q;
    assign Ctrl_out  = ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    // A bubble is counted on every edge that writes Valid_out=0; a stall writes nothing.
    assign stall_inc  = Stall_in & ~Flush_in;
    assign bubble_inc = Flush_in | (~Stall_in & ~Valid_in);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i  (Clk_in),
        .rst_ni (Reset_n_in),
        .inc_i  (stall_inc),
        .clr_i  (CntClr_in),
        .cnt_o  (StallCnt_out)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_bubble_cnt (
        .clk_i  (Clk_in),
        .rst_ni (Reset_n_in),
        .inc_i  (bubble_inc),
        .clr_i  (CntClr_in),
        .cnt_o  (BubbleCnt_out)
    );
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = CntClr_in;
    assign StallCnt_out   = '0;
    assign BubbleCnt_out  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a scoreboard of expected register contents.
// Counter expectations follow PIPE_STAGE_PERF_EN (zero when it is undefined).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned ND   = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned NA   = 2;
    localparam int unsigned CW   = CTRL_W;
    localparam int unsigned CNTW = 4;
    localparam logic [CW-1:0]   BUB     = CTRL_BUBBLE_DFLT;
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    typedef struct {
        logic            valid;
        logic [ND*DW-1:0] data;
        logic [NA*AW-1:0] raddr;
        logic [CW-1:0]   ctrl;
        logic [CNTW-1:0] scnt;
        logic [CNTW-1:0] bcnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             stall, flush, valid_in, cnt_clr;
    logic [ND*DW-1:0] data_in;
    logic [NA*AW-1:0] raddr_in;
    logic [CW-1:0]    ctrl_in;
    logic             valid_out;
    logic [ND*DW-1:0] data_out;
    logic [NA*AW-1:0] raddr_out;
    logic [CW-1:0]    ctrl_out;
    logic [CNTW-1:0]  scnt_out, bcnt_out;

    exp_t sb[$];
    exp_t m;
    int   n_chk  = 0;
    int   n_pass = 0;

    pipe_stage_reg #(
        .DATA_W      (DW),
        .NUM_DATA    (ND),
        .RADDR_W     (AW),
        .NUM_RADDR   (NA),
        .CTRL_W      (CW),
        .CTRL_BUBBLE (BUB),
        .CNT_W       (CNTW)
    ) dut (
        .Clk_in        (clk),
        .Reset_n_in    (rst_n),
        .Stall_in      (stall),
        .Flush_in      (flush),
        .Valid_in      (valid_in),
        .Data_in       (data_in),
        .Raddr_in      (raddr_in),
        .Ctrl_in       (ctrl_in),
        .CntClr_in     (cnt_clr),
        .Valid_out     (valid_out),
        .Data_out      (data_out),
        .Raddr_out     (raddr_out),
        .Ctrl_out      (ctrl_out),
        .StallCnt_out  (scnt_out),
        .BubbleCnt_out (bcnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ND*DW-1:0] obs, input logic [ND*DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, ND*DW'(valid_out), ND*DW'(e.valid));
        chk({tag, ".data"},  data_out, e.data);
        chk({tag, ".raddr"}, ND*DW'(raddr_out), ND*DW'(e.raddr));
        chk({tag, ".ctrl"},  ND*DW'(ctrl_out), ND*DW'(e.ctrl));
        chk({tag, ".scnt"},  ND*DW'(scnt_out), ND*DW'(e.scnt));
        chk({tag, ".bcnt"},  ND*DW'(bcnt_out), ND*DW'(e.bcnt));
    endtask

    function automatic exp_t reset_state();
        exp_t r;
        r.valid = 1'b0;
        r.data  = '0;
        r.raddr = '0;
        r.ctrl  = BUB;
        r.scnt  = '0;
        r.bcnt  = '0;
        return r;
    endfunction

    task automatic rand_inputs();
        stall    = 1'($urandom);
        flush    = 1'($urandom);
        valid_in = 1'($urandom);
        cnt_clr  = 1'($urandom);
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        raddr_in = NA*AW'($urandom);
        ctrl_in  = CW'($urandom);
    endtask

    // Drive one cycle, advance the model, push the expectation, then compare after the edge.
    task automatic step(input string tag, input logic st, input logic fl, input logic vi,
                        input logic [ND*DW-1:0] d, input logic [NA*AW-1:0] ra,
                        input logic [CW-1:0] c, input logic clr);
        exp_t e;
        stall = st; flush = fl; valid_in = vi; data_in = d; raddr_in = ra;
        ctrl_in = c; cnt_clr = clr;
        if (fl) begin
            m.valid = 1'b0; m.data = '0; m.raddr = '0; m.ctrl = BUB;
        end else if (!st) begin
            m.valid = vi; m.data = d; m.raddr = ra; m.ctrl = vi ? c : BUB;
        end
`ifdef PIPE_STAGE_PERF_EN
        if (clr) m.scnt = '0;
        else if (st && !fl && m.scnt != CNT_MAX) m.scnt = m.scnt + 1'b1;
        if (clr) m.bcnt = '0;
        else if ((fl || (!st && !vi)) && m.bcnt != CNT_MAX) m.bcnt = m.bcnt + 1'b1;
`endif
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s: scoreboard empty, got 0 entries want 1", tag);
        end else begin
            e = sb.pop_front();
            chk_all(tag, e);
        end
    endtask

    logic [ND*DW-1:0] va, vb;

    initial begin
        m     = reset_state();
        rst_n = 1'b0;
        rand_inputs();

        // Reset held with random inputs and a running clock.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_all("reset_hold", reset_state());
            rand_inputs();
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset is a normal load.
        step("load", 1'b0, 1'b0, 1'b1,
             {32'h0000_0010, 32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_0044},
             {5'd9, 5'd8}, 13'h1A41, 1'b0);

        step("clr0", 1'b0, 1'b0, 1'b1, '0, '0, 13'h0002, 1'b1);

        // Stall holds A for 3 cycles while B is presented.
        va = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        vb = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
        step("load_a", 1'b0, 1'b0, 1'b1, va, {5'd3, 5'd4}, 13'h0123, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b0, 1'b1, vb, {5'd30, 5'd31}, 13'h1F0F, 1'b0);
        end
        step("load_b", 1'b0, 1'b0, 1'b1, vb, {5'd30, 5'd31}, 13'h1F0F, 1'b0);

        // Flush beats a simultaneous stall.
        step("flush_stall", 1'b1, 1'b1, 1'b1, va, {5'd1, 5'd2}, 13'h1FFF, 1'b0);
        chk("flush_safe", ND*DW'(ctrl_writes(ctrl_out)), '0);

        // Upstream bubble: control forced to bubble, lanes still captured.
        step("bubble", 1'b0, 1'b0, 1'b0, vb, {5'd17, 5'd18}, 13'h1FFF, 1'b0);
        chk("bubble_safe", ND*DW'(ctrl_writes(ctrl_out)), '0);

        // Saturation then clear-over-increment.
        step("clr1", 1'b0, 1'b0, 1'b1, va, '0, 13'h0001, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, 1'b0, 1'b0, vb, '1, 13'h1234, 1'b0);
        end
        step("clr_stall", 1'b1, 1'b0, 1'b1, vb, '1, 13'h1234, 1'b1);

        for (int i = 0; i < 24; i++) begin
            step("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 NA*AW'($urandom), CW'($urandom), 1'($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset mid-stall clears outputs before any edge.
        step("pre_areset", 1'b0, 1'b0, 1'b1, va, {5'd5, 5'd6}, 13'h0F0F, 1'b0);
        stall = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m = reset_state();
        chk_all("async_reset", m);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", 1'b0, 1'b0, 1'b1, vb, {5'd7, 5'd8}, 13'h0A0A, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
